// File: rtl/dsp_fp32_issue_seq.sv
// -----------------------------------------------------------------------------
// dsp_fp32_issue_seq
//
// Issue sequencer that sits directly in front of dsp_slice_fp32. FP32 commands
// are buffered in a small FIFO. At most one command per cycle is driven onto
// the slice's registered enable/funct/accumulate/operand inputs. The first
// command of every accumulation group is issued with accumulate=0, and every
// later command of that group with accumulate=1. A valid/last shift register
// follows the slice pipeline, so res_valid/res_last mark the cycles in which
// resulta_flopped carries a real result.
//
// Ports
//   clk, clr             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    command handshake (see below)
//   in_funct, in_ax/ay/az, in_last
//                        command payload; in_last closes its accumulation group
//   stall                downstream back-pressure; freezes issue and the slice
//   dsp_enable, dsp_funct, dsp_accum, dsp_ax/ay/az
//                        registered slice inputs
//   res_valid, res_last  resulta_flopped holds a real result / closes a group
//   fifo_count           number of buffered commands
//   busy                 open group, buffered commands, or results in flight
//   dbg_state            FSM state (0 = IDLE, 1 = GROUP)
//
// Handshake: a command transfers on every rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the registered FIFO count
// (not full). A pop in the same cycle does not make room, so a full FIFO
// refuses the command even if it is draining that cycle. in_valid may drop
// or change freely while in_ready is 0.
// -----------------------------------------------------------------------------
module dsp_fp32_issue_seq #(
  parameter int DEPTH     = 4,
  parameter int SLICE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_funct,
  input  logic [31:0]                in_ax,
  input  logic [31:0]                in_ay,
  input  logic [31:0]                in_az,
  input  logic                       in_last,
  input  logic                       stall,
  output logic                       dsp_enable,
  output logic [3:0]                 dsp_funct,
  output logic                       dsp_accum,
  output logic [31:0]                dsp_ax,
  output logic [31:0]                dsp_ay,
  output logic [31:0]                dsp_az,
  output logic                       res_valid,
  output logic                       res_last,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy,
  output logic                       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 1 + 4 + 3 * 32;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GROUP = 1'b1;

  // FIFO storage: {last, funct, ax, ay, az}
  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;

  logic [0:0]           state_q;
  logic [0:0]           state_d;

  logic                 en_q;
  logic                 en_d;
  logic                 accum_q;
  logic                 accum_d;
  logic                 real_q;      // the command on the slice inputs is real (not a bubble)
  logic                 real_d;
  logic                 last_q;      // the command on the slice inputs closes a group
  logic                 last_d;
  logic [3:0]           funct_q;
  logic [31:0]          ax_q;
  logic [31:0]          ay_q;
  logic [31:0]          az_q;

  logic [SLICE_LAT-1:0] vld_sr_q;
  logic [SLICE_LAT-1:0] vld_sr_d;
  logic [SLICE_LAT-1:0] lst_sr_q;
  logic [SLICE_LAT-1:0] lst_sr_d;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 inflight;

  logic                 head_last;
  logic [3:0]           head_funct;
  logic [31:0]          head_ax;
  logic [31:0]          head_ay;
  logic [31:0]          head_az;

  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign fifo_empty = (count_q == '0);

  assign {head_last, head_funct, head_ax, head_ay, head_az} = mem_q[rd_ptr_q];

  // A real command sitting on the slice inputs this cycle counts as in flight.
  // This keeps the bubbles going from the first enabled cycle, so a lone
  // command still sees its result SLICE_LAT enabled cycles later.
  assign inflight = (|vld_sr_q) | (en_q & real_q);

  // Issue decision for the next cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    en_d    = 1'b0;
    accum_d = 1'b0;
    real_d  = 1'b0;
    last_d  = 1'b0;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            en_d    = 1'b1;
            real_d  = 1'b1;
            last_d  = head_last;
            state_d = head_last ? S_IDLE : S_GROUP;
          end else if (inflight) begin
            // Bubble: flushes pending results out of the slice; no group is
            // open, so the accumulator holds nothing worth keeping.
            en_d = 1'b1;
          end
        end
        S_GROUP: begin
          // An empty FIFO leaves the slice frozen. A bubble here would
          // corrupt the running accumulation.
          if (!fifo_empty) begin
            pop     = 1'b1;
            en_d    = 1'b1;
            accum_d = 1'b1;
            real_d  = 1'b1;
            last_d  = head_last;
            if (head_last) begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  generate
    if (SLICE_LAT == 1) begin : g_sr_one
      assign vld_sr_d = real_q;
      assign lst_sr_d = last_q;
    end else begin : g_sr_multi
      assign vld_sr_d = {vld_sr_q[SLICE_LAT-2:0], real_q};
      assign lst_sr_d = {lst_sr_q[SLICE_LAT-2:0], last_q};
    end
  endgenerate

  // Payload storage needs no reset; the pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_funct, in_ax, in_ay, in_az};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      accum_q  <= 1'b0;
      real_q   <= 1'b0;
      last_q   <= 1'b0;
      funct_q  <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      az_q     <= '0;
      vld_sr_q <= '0;
      lst_sr_q <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      en_q    <= en_d;
      accum_q <= accum_d;
      real_q  <= real_d;
      last_q  <= last_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        funct_q  <= head_funct;
        ax_q     <= head_ax;
        ay_q     <= head_ay;
        az_q     <= head_az;
      end
      // The tracker advances only on edges where the slice advances.
      if (en_q) begin
        vld_sr_q <= vld_sr_d;
        lst_sr_q <= lst_sr_d;
      end
    end
  end

  assign dsp_enable = en_q;
  assign dsp_funct  = funct_q;
  assign dsp_accum  = accum_q;
  assign dsp_ax     = ax_q;
  assign dsp_ay     = ay_q;
  assign dsp_az     = az_q;
  assign res_valid  = vld_sr_q[SLICE_LAT-1];
  assign res_last   = lst_sr_q[SLICE_LAT-1] & res_valid;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0) | inflight;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dsp_fp32_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_dsp_fp32_issue_seq
//
// Bench for dsp_fp32_issue_seq. A behavioural model runs on the falling edge.
// It tracks the command queue, whether a group is open, and which issue
// indices are still travelling through the slice. From these it predicts the
// outputs of the next cycle. A separate monitor compares those predictions
// with the DUT, and retires expected results as the slice shifts them out.
// -----------------------------------------------------------------------------
module tb_dsp_fp32_issue_seq;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT ----------------
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_funct;
  logic [31:0]   in_ax;
  logic [31:0]   in_ay;
  logic [31:0]   in_az;
  logic          in_last;
  logic          stall;
  logic          dsp_enable;
  logic [3:0]    dsp_funct;
  logic          dsp_accum;
  logic [31:0]   dsp_ax;
  logic [31:0]   dsp_ay;
  logic [31:0]   dsp_az;
  logic          res_valid;
  logic          res_last;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          dbg_state;

  dsp_fp32_issue_seq #(.DEPTH(DEPTH), .SLICE_LAT(LAT)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_ax      (in_ax),
    .in_ay      (in_ay),
    .in_az      (in_az),
    .in_last    (in_last),
    .stall      (stall),
    .dsp_enable (dsp_enable),
    .dsp_funct  (dsp_funct),
    .dsp_accum  (dsp_accum),
    .dsp_ax     (dsp_ax),
    .dsp_ay     (dsp_ay),
    .dsp_az     (dsp_az),
    .res_valid  (res_valid),
    .res_last   (res_last),
    .fifo_count (fifo_count),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0]  funct;
    logic [31:0] ax;
    logic [31:0] ay;
    logic [31:0] az;
    logic        last;
  } cmd_t;

  typedef struct {
    int          stamp;
    logic        en;
    logic        accum;
    cmd_t        op;
    logic [CW-1:0] cnt;
    logic        rdy;
    logic        bsy;
    logic        grp;
    int          idx;
  } pred_t;

  int   checks = 0;
  int   errors = 0;
  bit   rand_stall = 1'b0;

  pred_t      pred_q[$];      // expected per-cycle slice-side outputs
  logic [32:0] exp_q[$];      // expected results: {last, enabled-cycle index when shifted out}

  cmd_t fifo_m[$];            // commands accepted but not yet issued
  bit   group_m = 1'b0;
  cmd_t held_m  = '0;
  int   idx_m   = 0;          // index of the current/next enabled cycle
  bit   en_m    = 1'b0;
  int   iss_m[$];             // enabled-cycle indices of real issues still in the slice

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Real results still inside the slice when the enabled-cycle index is k.
  function automatic int inflight(input int k);
    int n = 0;
    foreach (iss_m[i]) begin
      if (iss_m[i] <= k && iss_m[i] + LAT >= k) n++;
    end
    return n;
  endfunction

  // ---------------- reference model ----------------
  always @(negedge clk) begin : model
    pred_t p;
    cmd_t  c;
    bit    do_push;
    bit    do_pop;
    bit    do_bubble;
    p.accum = 1'b0;
    if (clr) begin
      fifo_m.delete();
      iss_m.delete();
      exp_q.delete();
      pred_q.delete();
      group_m = 1'b0;
      held_m  = '0;
      idx_m   = 0;
      en_m    = 1'b0;
      p.stamp = cyc + 1;
      p.en    = 1'b0;
      p.op    = '0;
      p.cnt   = '0;
      p.rdy   = 1'b1;
      p.bsy   = 1'b0;
      p.grp   = 1'b0;
      p.idx   = 0;
      pred_q.push_back(p);
    end else begin
      do_push   = in_valid && (fifo_m.size() != DEPTH);
      do_pop    = !stall && (fifo_m.size() != 0);
      do_bubble = !stall && (fifo_m.size() == 0) && !group_m && (inflight(idx_m) > 0);
      if (en_m) idx_m++;
      if (do_pop) begin
        c       = fifo_m.pop_front();
        p.accum = group_m;
        group_m = !c.last;
        held_m  = c;
        iss_m.push_back(idx_m);
        exp_q.push_back({c.last, 32'(idx_m + LAT)});
      end
      if (do_push) fifo_m.push_back({in_funct, in_ax, in_ay, in_az, in_last});
      en_m = do_pop || do_bubble;
      while (iss_m.size() != 0 && iss_m[0] + LAT < idx_m) void'(iss_m.pop_front());
      p.stamp = cyc + 1;
      p.en    = en_m;
      p.op    = held_m;
      p.cnt   = CW'(fifo_m.size());
      p.rdy   = (fifo_m.size() != DEPTH);
      p.grp   = group_m;
      p.bsy   = group_m || (fifo_m.size() != 0) || (inflight(idx_m) > 0);
      p.idx   = idx_m;
      pred_q.push_back(p);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    pred_t p;
    bit    rv;
    bit    rl;
    if (!clr) begin
      while (pred_q.size() != 0 && pred_q[0].stamp < cyc) void'(pred_q.pop_front());
      if (pred_q.size() != 0 && pred_q[0].stamp == cyc) begin
        p = pred_q.pop_front();
        chk("dsp_enable", dsp_enable, p.en);
        chk("fifo_count", fifo_count, p.cnt);
        chk("in_ready",   in_ready,   p.rdy);
        chk("busy",       busy,       p.bsy);
        chk("state",      dbg_state,  p.grp);
        chk("dsp_funct",  dsp_funct,  p.op.funct);
        chk("dsp_ax",     dsp_ax,     p.op.ax);
        chk("dsp_ay",     dsp_ay,     p.op.ay);
        chk("dsp_az",     dsp_az,     p.op.az);
        if (p.en) chk("dsp_accum", dsp_accum, p.accum);
        rv = (exp_q.size() != 0) && (exp_q[0][31:0] == 32'(p.idx));
        rl = rv && exp_q[0][32];
        chk("res_valid", res_valid, rv);
        chk("res_last",  res_last,  rl);
        if (p.en && rv) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic cmd_t mk(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] z, input logic l);
    cmd_t c;
    c.funct = f; c.ax = x; c.ay = y; c.az = z; c.last = l;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd(input logic l);
    return mk(4'($urandom_range(0, 15)), $urandom(), $urandom(), $urandom(), l);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic send(input cmd_t c, input int max_wait, input bit must);
    bit ok;
    bit rdy;
    in_valid = 1'b1;
    in_funct = c.funct;
    in_ax    = c.ax;
    in_ay    = c.ay;
    in_az    = c.az;
    in_last  = c.last;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
      ok = rdy;
    end
    in_valid = 1'b0;
    if (must) chk("send_accept", ok, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = !busy && !dsp_enable && (exp_q.size() == 0) && (fifo_m.size() == 0);
    end
    @(posedge clk); #1;
    chk("idle_reached", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable"}, dsp_enable, 0);
    chk({tag, "_accum"},  dsp_accum,  0);
    chk({tag, "_funct"},  dsp_funct,  0);
    chk({tag, "_ax"},     dsp_ax,     0);
    chk({tag, "_ay"},     dsp_ay,     0);
    chk({tag, "_az"},     dsp_az,     0);
    chk({tag, "_rvalid"}, res_valid,  0);
    chk({tag, "_rlast"},  res_last,   0);
    chk({tag, "_count"},  fifo_count, 0);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_ready"},  in_ready,   1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    clr      = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    in_funct = '0;
    in_ax    = '0;
    in_ay    = '0;
    in_az    = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    clr = 1'b0;
    tick(2);

    // single operation
    send(mk(4'b0001, 32'hC0D1C2F2, 32'h3E1FF44D, 32'h3F5A572F, 1'b1), 20, 1);
    wait_idle(50);

    // group of four, back to back
    for (int i = 0; i < 4; i++) send(mk(4'b0011, $urandom(), $urandom(), $urandom(), i == 3), 20, 1);
    wait_idle(50);

    // mid-group underflow: the slice must freeze, not bubble
    send(rnd_cmd(1'b0), 20, 1);
    send(rnd_cmd(1'b0), 20, 1);
    tick(5);
    send(rnd_cmd(1'b1), 20, 1);
    wait_idle(50);

    // full FIFO under stall: only four of six offers are taken
    stall = 1'b1;
    for (int i = 0; i < 6; i++) send(mk(4'(i), $urandom(), $urandom(), $urandom(), 1'b1), 1, 0);
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", in_ready, 0);
    chk("full_enable", dsp_enable, 0);
    stall = 1'b0;
    wait_idle(50);

    // stall while results are draining
    for (int i = 0; i < 5; i++) send(rnd_cmd(i == 4), 20, 1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = res_valid;
      if (!found) begin
        @(posedge clk); #1;
      end
    end
    chk("drain_seen", found, 1);
    @(posedge clk); #1;
    stall = 1'b1;
    tick(3);
    chk("stall_hold_valid", res_valid, 1);
    chk("stall_enable", dsp_enable, 0);
    stall = 1'b0;
    wait_idle(50);

    // reset in the middle of an open group with three commands queued
    send(rnd_cmd(1'b0), 20, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) send(rnd_cmd(i == 2), 20, 1);
    tick(1);
    clr = 1'b1;
    #1;
    check_reset_outputs("clr");
    tick(1);
    clr   = 1'b0;
    stall = 1'b0;
    send(mk(4'h7, $urandom(), $urandom(), $urandom(), 1'b1), 20, 1);
    wait_idle(50);

    // randomized traffic with random stalls and gaps
    rand_stall = 1'b1;
    for (int n = 0; n < 150; n++) begin
      in_valid = 1'b0;
      tick($urandom_range(0, 2));
      send(rnd_cmd((n == 149) ? 1'b1 : 1'($urandom_range(0, 2) == 0)), 60, 1);
    end
    rand_stall = 1'b0;
    stall      = 1'b0;
    wait_idle(200);

    chk("results_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
